// File: rtl/alu_top.sv
// alu_top: registered two-operand ALU with ADD, SUB, AND and OR.
// All outputs are registered, so a result appears one cycle after its
// operands are sampled. A new operation can be issued every cycle.
// Optional feature macro: ALU_ERR_FLAG_EN. When it is defined, `error`
// flags an ADD/SUB carry/borrow or signed overflow. When it is not
// defined, `error` is tied to 0 and no error register is built.
module alu_top #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             error
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  localparam int MSB = WIDTH - 1;

  op_e              op;
  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic [WIDTH-1:0] out_d, out_q;
  logic             zero_d, zero_q;
  logic             carry_d, carry_q;
  logic             overflow_d, overflow_q;

  assign op = op_e'(sel);

  // Next result and flags for the operation currently on the inputs.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave it unassigned and infer a latch.
    out_d      = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    sum_add    = {1'b0, a} + {1'b0, b};
    // The subtract is done as a + ~b + 1. Its carry-out is the inverse of the borrow.
    sum_sub    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    unique case (op)
      OP_ADD: begin
        out_d      = sum_add[WIDTH-1:0];
        carry_d    = sum_add[WIDTH];
        overflow_d = (a[MSB] == b[MSB]) && (sum_add[MSB] != a[MSB]);
      end
      OP_SUB: begin
        out_d      = sum_sub[WIDTH-1:0];
        carry_d    = ~sum_sub[WIDTH];
        overflow_d = (a[MSB] != b[MSB]) && (sum_sub[MSB] != a[MSB]);
      end
      OP_AND: out_d = a & b;
      OP_OR:  out_d = a | b;
      default: out_d = '0;
    endcase
    zero_d = (out_d == '0);
  end

  // Output registers, cleared asynchronously while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every flop samples its pre-edge value.
      out_q      <= out_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef ALU_ERR_FLAG_EN
  logic error_d, error_q;

  // Arithmetic exception: carry/borrow or signed overflow on ADD and SUB only.
  always_comb begin
    error_d = 1'b0;
    if (op == OP_ADD || op == OP_SUB) error_d = carry_d | overflow_d;
  end

  // Error register, kept in step with the other outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) error_q <= 1'b0;
    else        error_q <= error_d;
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign out      = out_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: self-checking bench for alu_top. It runs a WIDTH=2 instance
// (directed cases plus an exhaustive sweep) alongside a WIDTH=8 instance
// (random sweep). Expected values come from an integer-arithmetic model
// of the ALU rules.
module tb_alu_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] a2 = '0, b2 = '0, s2 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [1:0] s8 = '0;
  logic [1:0] out2;
  logic [7:0] out8;
  logic       z2, c2, v2, e2, z8, c8, v8, e8;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [31:0] exp2 = '0, exp8 = '0;

  always #5 clk = ~clk;

  alu_top #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .sel(s2),
    .out(out2), .zero(z2), .carry(c2), .overflow(v2), .error(e2)
  );

  alu_top #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(s8),
    .out(out8), .zero(z8), .carry(c8), .overflow(v8), .error(e8)
  );

  // Packed layout: [19] error [18] overflow [17] carry [16] zero [15:0] out
  function automatic logic [31:0] obs2();
    return {12'b0, e2, v2, c2, z2, 14'b0, out2};
  endfunction

  function automatic logic [31:0] obs8();
    return {12'b0, e8, v8, c8, z8, 8'b0, out8};
  endfunction

  // Reference model: plain unsigned/signed integer arithmetic.
  function automatic logic [31:0] ref_alu(int w, int a, int b, int s);
    int m, h, sa, sb, r, sr;
    bit cy, ov, er;
    m = 1 << w;
    h = m / 2;
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    r = 0; sr = 0; cy = 0; ov = 0; er = 0;
    case (s)
      0: begin r = (a + b) % m; cy = (a + b) >= m; sr = sa + sb; ov = (sr >= h) || (sr < -h); end
      1: begin r = (a - b + m) % m; cy = a < b; sr = sa - sb; ov = (sr >= h) || (sr < -h); end
      2: r = a & b;
      default: r = a | b;
    endcase
`ifdef ALU_ERR_FLAG_EN
    er = (s < 2) && (cy || ov);
`endif
    return {12'b0, er, ov, cy, (r == 0), 16'(r)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (err,ovf,cy,zero | out)", tag, got, exp);
    end
  endtask

  // At the falling edge: confirm the outputs held, then drive new operands.
  // Just after the next rising edge: compare against the model.
  task automatic step(input logic [1:0] na, input logic [1:0] nb, input logic [1:0] ns,
                      input logic [7:0] ma, input logic [7:0] mb, input logic [1:0] ms,
                      input string tag);
    @(negedge clk);
    check({tag, "_hold_w2"}, obs2(), exp2);
    check({tag, "_hold_w8"}, obs8(), exp8);
    a2 = na; b2 = nb; s2 = ns;
    a8 = ma; b8 = mb; s8 = ms;
    exp2 = ref_alu(2, int'(na), int'(nb), int'(ns));
    exp8 = ref_alu(8, int'(ma), int'(mb), int'(ms));
    @(posedge clk);
    #1;
    check({tag, "_w2"}, obs2(), exp2);
    check({tag, "_w8"}, obs8(), exp8);
  endtask

  // Release reset at a falling edge with fresh operands. The very next
  // rising edge must produce their result.
  task automatic release_with(input logic [1:0] na, input logic [1:0] nb, input logic [1:0] ns,
                              input string tag);
    @(negedge clk);
    a2 = na; b2 = nb; s2 = ns;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 2'($urandom);
    rst_n = 1'b1;
    exp2 = ref_alu(2, int'(a2), int'(b2), int'(s2));
    exp8 = ref_alu(8, int'(a8), int'(b8), int'(s8));
    @(posedge clk);
    #1;
    check({tag, "_w2"}, obs2(), exp2);
    check({tag, "_w8"}, obs8(), exp8);
  endtask

  initial begin
    logic [31:0] e_exp;
    // Reset state, including across a clock edge with nonzero inputs.
    a2 = 2'b11; b2 = 2'b01; s2 = 2'b00; a8 = 8'hff; b8 = 8'h01; s8 = 2'b00;
    #2;
    check("reset_w2", obs2(), 32'h0);
    check("reset_w8", obs8(), 32'h0);
    @(posedge clk);
    #1;
    check("reset_edge_w2", obs2(), 32'h0);
    check("reset_edge_w8", obs8(), 32'h0);

    // First edge after release: ADD 01+01 -> out=10, overflow=1.
    release_with(2'b01, 2'b01, 2'b00, "first_edge");
    check("add_01_01_out", 32'(out2), 32'h2);
    check("add_01_01_ovf", 32'(v2), 32'h1);

    // Directed WIDTH=2 cases.
    step(2'b11, 2'b01, 2'b00, 8'hff, 8'h01, 2'b00, "add_wrap");
    check("add_wrap_zero", 32'(z2), 32'h1);
    check("add_wrap_carry", 32'(c2), 32'h1);
`ifdef ALU_ERR_FLAG_EN
    e_exp = 32'h1;
`else
    e_exp = 32'h0;
`endif
    check("add_wrap_error", 32'(e2), e_exp);
    step(2'b11, 2'b01, 2'b01, 8'h80, 8'h01, 2'b01, "sub_3_1");
    check("sub_3_1_out", 32'(out2), 32'h2);
    step(2'b01, 2'b11, 2'b01, 8'h01, 8'hff, 2'b01, "sub_borrow");
    check("sub_borrow_carry", 32'(c2), 32'h1);
    step(2'b11, 2'b01, 2'b10, 8'hf0, 8'h3c, 2'b10, "and");
    step(2'b10, 2'b01, 2'b11, 8'h00, 8'h00, 2'b11, "or");
    check("or_out", 32'(out2), 32'h3);

    // Asynchronous reset between edges while nonzero results are held.
    step(2'b01, 2'b01, 2'b00, 8'h7f, 8'h01, 2'b00, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_w2", obs2(), 32'h0);
    check("async_rst_w8", obs8(), 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_w2", obs2(), 32'h0);
    check("rst_hold_w8", obs8(), 32'h0);
    release_with(2'b10, 2'b11, 2'b01, "post_rst");

    // Exhaustive WIDTH=2 sweep, with random WIDTH=8 traffic alongside.
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          step(2'(a), 2'(b), 2'(s), 8'($urandom), 8'($urandom), 2'($urandom), "sweep");

    // Random sweep on both widths. The WIDTH=8 operands are biased toward edge values.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 8'hff : 8'h80;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 8'h7f : 8'h00;
      step(2'($urandom), 2'($urandom), 2'($urandom), ra, rb, 2'($urandom), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_top.md
ALU_TOP -- requirements
Module: alu_top

Interface
REQ-001 Parameter: WIDTH, default 2, operand and result width in bits; legal values 2..16.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: a  input  WIDTH  operand A, unsigned or two's complement by operation.
REQ-005 Port: b  input  WIDTH  operand B.
REQ-006 Port: sel  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-007 Port: out  output  WIDTH  registered result.
REQ-008 Port: zero  output  1  registered; high when out is all zeros.
REQ-009 Port: carry  output  1  registered; ADD carry-out, SUB borrow.
REQ-010 Port: overflow  output  1  registered; two's-complement signed overflow.
REQ-011 Port: error  output  1  registered arithmetic-exception flag (see Configuration).
REQ-012 Design has one clock domain; the reset is asynchronous and active-low.

Function
REQ-013 a, b and sel are sampled on every rising clk edge; all outputs update together on that edge, giving one-cycle latency.
REQ-014 No handshake: a new operation is accepted every cycle; outputs hold until the next edge.
REQ-015 ADD: out = (a + b) mod 2^WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit unsigned sum.
REQ-016 SUB: out = (a - b) mod 2^WIDTH; carry = 1 only when a < b unsigned (borrow); implemented as a + ~b + 1.
REQ-017 ADD overflow = 1 when a and b have equal MSBs and the result MSB differs from them.
REQ-018 SUB overflow = 1 when a and b have different MSBs and the result MSB differs from the MSB of a.
REQ-019 AND: out = a & b. OR: out = a | b. For both, carry = 0 and overflow = 0.
REQ-020 zero = 1 when the registered out equals 0, for every opcode.
REQ-021 Wrap-around is silent: out is always the low WIDTH bits; no saturation.
REQ-022 Outputs are purely a function of the previous edge's sampled inputs; there is no accumulated state beyond the output registers.

Reset
REQ-023 While rst_n = 0, out, zero, carry, overflow and error are all 0, regardless of clk.
REQ-024 Assertion mid-operation clears the outputs immediately; the operation in flight is discarded.
REQ-025 On the first rising edge after rst_n returns to 1, the block samples inputs normally; no warm-up cycles.

Configuration
REQ-026 Macro ALU_ERR_FLAG_EN: when defined, error = (carry | overflow) for ADD and SUB and 0 for AND and OR, registered alongside the other outputs.
REQ-027 When ALU_ERR_FLAG_EN is undefined, error is held constant 0 and no error logic is synthesized; all other behaviour is identical.

Verification
REQ-028 WIDTH=2, sel=00, a=01, b=01 -> next edge: out=10, zero=0, carry=0, overflow=1.
REQ-029 sel=00, a=11, b=01 -> out=00, zero=1, carry=1, overflow=0; error=1 with ALU_ERR_FLAG_EN, else 0.
REQ-030 sel=01, a=11, b=01 -> out=10, zero=0, carry=0, overflow=0; then a=01, b=11 -> out=10, carry=1.
REQ-031 sel=10, a=11, b=01 -> out=01, flags 0. Then sel=11, a=10, b=01 -> out=11, zero=0, carry=0, overflow=0.
REQ-032 With valid nonzero outputs registered, drive rst_n=0 between clock edges -> all outputs 0 immediately. Release rst_n -> the next edge computes from the current inputs.
REQ-033 Exhaustive sweep of all a, b and sel values for WIDTH=2, plus a random sweep for WIDTH=8, with outputs compared one cycle later against a reference model.
